// File: rtl/duck_shot_scorer.sv
// duck_shot_scorer: turns a left mouse click into a single shot, resolves it
// against the duck hitbox, and keeps shots-left, ducks-hit, round-over and a
// saturating 3-digit BCD score for the HEX displays.
// Optional feature macro: SCORER_STREAK_EN (third and later consecutive hits
// score double, taking one extra evaluation cycle).
module duck_shot_scorer #(
  parameter int DUCK_W          = 32,
  parameter int DUCK_H          = 32,
  parameter int SHOTS_PER_DUCK  = 3,
  parameter int POINTS_PER_HIT  = 5,
  parameter int DUCKS_PER_ROUND = 10,
  parameter int COOLDOWN_FRAMES = 6
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        VS,
  input  logic [7:0]  MouseButtons,
  input  logic [9:0]  CursorX,
  input  logic [9:0]  CursorY,
  input  logic [9:0]  Duck_X,
  input  logic [9:0]  Duck_Y,
  input  logic        duck_active,
  input  logic        duck_launch,
  input  logic        new_game,
  output logic        hit_pulse,
  output logic        miss_pulse,
  output logic        out_of_shots,
  output logic [1:0]  shots_left,
  output logic [3:0]  ducks_hit,
  output logic        round_over,
  output logic [11:0] score_bcd
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_EVAL,
    S_EVAL2,
    S_COOLDOWN
  } state_t;

  localparam logic [3:0]  PTS       = 4'(POINTS_PER_HIT);
  localparam logic [3:0]  DPR       = 4'(DUCKS_PER_ROUND);
  localparam logic [1:0]  SHOTS     = 2'(SHOTS_PER_DUCK);
  localparam logic [7:0]  CD_LAST   = 8'(COOLDOWN_FRAMES - 1);
  localparam logic [10:0] BOX_W     = 11'(DUCK_W);
  localparam logic [10:0] BOX_H     = 11'(DUCK_H);

  // Only the left button matters; the other buttons are deliberately ignored.
  logic unused_buttons;
  assign unused_buttons = ^MouseButtons[7:1];

  logic [1:0]  btn_sync_q, vs_sync_q;
  logic        btn_prev_q, vs_prev_q;
  logic        click, tick;

  state_t      state_q, state_d;
  logic [9:0]  cx_q, cx_d, cy_q, cy_d, dx_q, dx_d, dy_q, dy_d;
  logic [7:0]  cd_cnt_q, cd_cnt_d;
  logic [1:0]  shots_q, shots_d;
  logic [3:0]  ducks_q, ducks_d;
  logic [11:0] score_q, score_d;
  logic        hit_q, hit_d, miss_q, miss_d, oos_q, oos_d, round_q, round_d;
`ifdef SCORER_STREAK_EN
  logic [1:0]  streak_q, streak_d;
`endif

  logic [10:0] x_lim, y_lim;
  logic        shot_hit;
  logic        resolve, resolve_hit;

  // Add one hit's worth of points to a BCD score, ripple the decimal carry
  // and pin the result at 999 instead of wrapping.
  function automatic logic [11:0] bcd_add_sat(input logic [11:0] s, input logic [3:0] p);
    logic [4:0] ones, tens, hund;
    ones = {1'b0, s[3:0]} + {1'b0, p};
    tens = {1'b0, s[7:4]};
    hund = {1'b0, s[11:8]};
    if (ones > 5'd9) begin
      ones = ones - 5'd10;
      tens = tens + 5'd1;
    end
    if (tens > 5'd9) begin
      tens = tens - 5'd10;
      hund = hund + 5'd1;
    end
    if (hund > 5'd9) return 12'h999;
    return {hund[3:0], tens[3:0], ones[3:0]};
  endfunction

  assign click = btn_sync_q[1] & ~btn_prev_q;
  assign tick  = vs_sync_q[1] & ~vs_prev_q;

  // Hitbox test on the latched coordinates; 11-bit sums so a box near the
  // right/bottom edge of the 10-bit range never wraps.
  always_comb begin
    x_lim    = {1'b0, dx_q} + BOX_W;
    y_lim    = {1'b0, dy_q} + BOX_H;
    shot_hit = (cx_q >= dx_q) && ({1'b0, cx_q} < x_lim) &&
               (cy_q >= dy_q) && ({1'b0, cy_q} < y_lim);
  end

  // Next-state logic: FSM sequencing, shot resolution, reload and new-game overrides.
  always_comb begin
    state_d     = state_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    cd_cnt_d    = cd_cnt_q;
    shots_d     = shots_q;
    ducks_d     = ducks_q;
    score_d     = score_q;
    hit_d       = 1'b0;
    miss_d      = 1'b0;
    oos_d       = 1'b0;
    resolve     = 1'b0;
    resolve_hit = 1'b0;
`ifdef SCORER_STREAK_EN
    streak_d    = streak_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (duck_active && shots_q != 2'd0) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (!duck_active || shots_q == 2'd0) begin
          state_d = S_IDLE;
        end else if (click) begin
          cx_d    = CursorX;
          cy_d    = CursorY;
          dx_d    = Duck_X;
          dy_d    = Duck_Y;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
`ifdef SCORER_STREAK_EN
        if (shot_hit && streak_q >= 2'd2) begin
          score_d = bcd_add_sat(score_q, PTS);
          state_d = S_EVAL2;
        end else begin
          resolve     = 1'b1;
          resolve_hit = shot_hit;
        end
`else
        resolve     = 1'b1;
        resolve_hit = shot_hit;
`endif
      end
      S_EVAL2: begin
        resolve     = 1'b1;
        resolve_hit = 1'b1;
      end
      S_COOLDOWN: begin
        if (tick) begin
          if (cd_cnt_q == CD_LAST) state_d = S_IDLE;
          else cd_cnt_d = cd_cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (resolve) begin
      state_d  = S_COOLDOWN;
      cd_cnt_d = 8'd0;
      if (resolve_hit) begin
        hit_d   = 1'b1;
        score_d = bcd_add_sat(score_q, PTS);
        if (ducks_q < DPR) ducks_d = ducks_q + 4'd1;
`ifdef SCORER_STREAK_EN
        if (streak_q != 2'd3) streak_d = streak_q + 2'd1;
`endif
      end else begin
        miss_d = 1'b1;
        if (shots_q != 2'd0) begin
          shots_d = shots_q - 2'd1;
          oos_d   = (shots_q == 2'd1);
        end
`ifdef SCORER_STREAK_EN
        streak_d = 2'd0;
`endif
      end
    end

    if (duck_launch) begin
      shots_d = SHOTS;
      oos_d   = 1'b0;
    end

    if (new_game) begin
      score_d = 12'h000;
      ducks_d = 4'd0;
      state_d = S_IDLE;
`ifdef SCORER_STREAK_EN
      streak_d = 2'd0;
`endif
    end

    round_d = (ducks_d == DPR);
  end

  // State, synchronizer and registered-output flops.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      btn_sync_q <= 2'b00;
      vs_sync_q  <= 2'b00;
      btn_prev_q <= 1'b0;
      vs_prev_q  <= 1'b0;
      state_q    <= S_IDLE;
      cx_q       <= 10'd0;
      cy_q       <= 10'd0;
      dx_q       <= 10'd0;
      dy_q       <= 10'd0;
      cd_cnt_q   <= 8'd0;
      shots_q    <= 2'd0;
      ducks_q    <= 4'd0;
      score_q    <= 12'h000;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
      oos_q      <= 1'b0;
      round_q    <= 1'b0;
`ifdef SCORER_STREAK_EN
      streak_q   <= 2'd0;
`endif
    end else begin
      btn_sync_q <= {btn_sync_q[0], MouseButtons[0]};
      vs_sync_q  <= {vs_sync_q[0], VS};
      btn_prev_q <= btn_sync_q[1];
      vs_prev_q  <= vs_sync_q[1];
      state_q    <= state_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      cd_cnt_q   <= cd_cnt_d;
      shots_q    <= shots_d;
      ducks_q    <= ducks_d;
      score_q    <= score_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
      oos_q      <= oos_d;
      round_q    <= round_d;
`ifdef SCORER_STREAK_EN
      streak_q   <= streak_d;
`endif
    end
  end

  assign hit_pulse    = hit_q;
  assign miss_pulse   = miss_q;
  assign out_of_shots = oos_q;
  assign shots_left   = shots_q;
  assign ducks_hit    = ducks_q;
  assign round_over   = round_q;
  assign score_bcd    = score_q;

endmodule
